// File: rtl/html_char_stream.sv
// Streams a document from a 1-cycle-latency synchronous memory through a small
// FIFO onto a valid/ready character interface, with optional NUL termination.
module html_char_stream #(
   parameter int CHAR_WIDTH       = 8,
   parameter int ADDR_WIDTH       = 16,
   parameter int FIFO_DEPTH       = 4,
   parameter int TERMINATE_ON_NUL = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] doc_length,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [CHAR_WIDTH-1:0] mem_data,
   output logic [CHAR_WIDTH-1:0] char,
   output logic                  char_valid,
   input  logic                  char_ready,
   output logic [ADDR_WIDTH-1:0] char_index,
   output logic                  busy,
   output logic                  has_finished
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]      DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1'b1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [ADDR_WIDTH-1:0]   len_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   idx_r;
   logic [CHAR_WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [CNT_W-1:0]        count_r;
   logic                    inflight_r;
   logic                    stop_r;
   logic                    busy_r;
   logic                    finished_r;

   logic                    start_ok_s;
   logic                    issue_s;
   logic                    ret_nul_s;
   logic                    push_s;
   logic                    pop_s;
   logic [CNT_W:0]          occ_s;

   // Issue, push and pop qualifiers; occupancy counts the in-flight read so the FIFO never overflows.
   always_comb begin
      occ_s      = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
      start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
      issue_s    = (state_r == ST_FETCH) && (addr_r < len_r) && (occ_s < DEPTH_C);
      if (inflight_r && !stop_r && (TERMINATE_ON_NUL != 0) && (mem_data == {CHAR_WIDTH{1'b0}})) begin
         ret_nul_s = 1'b1;
      end else begin
         ret_nul_s = 1'b0;
      end
      push_s = inflight_r && !stop_r && !ret_nul_s;
      pop_s  = (count_r != {CNT_W{1'b0}}) && char_ready;
   end

   // Next-state logic of the fetch sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = (doc_length == {ADDR_WIDTH{1'b0}}) ? ST_DONE : ST_FETCH;
            end else begin
               state_s = state_r;
            end
         end
         ST_FETCH: begin
            if (ret_nul_s || (addr_r == len_r)) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if ((count_r == {CNT_W{1'b0}}) && !inflight_r) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencer state, fetch address, stream index and status registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         len_r      <= {ADDR_WIDTH{1'b0}};
         addr_r     <= {ADDR_WIDTH{1'b0}};
         idx_r      <= {ADDR_WIDTH{1'b0}};
         inflight_r <= 1'b0;
         stop_r     <= 1'b0;
         busy_r     <= 1'b0;
         finished_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         inflight_r <= issue_s;
         busy_r     <= (state_s == ST_FETCH) || (state_s == ST_DRAIN);
         finished_r <= (state_s == ST_DONE);
         if (start_ok_s) begin
            len_r  <= doc_length;
            addr_r <= {ADDR_WIDTH{1'b0}};
            idx_r  <= {ADDR_WIDTH{1'b0}};
            stop_r <= 1'b0;
         end else begin
            if (issue_s) begin
               addr_r <= addr_r + ADDR_ONE;
            end
            if (pop_s) begin
               idx_r <= idx_r + ADDR_ONE;
            end
            if (ret_nul_s) begin
               stop_r <= 1'b1;
            end
         end
      end
   end

   // Character FIFO storage and pointers; the head entry only moves on a pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {CHAR_WIDTH{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_data;
            wr_ptr_r             <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign mem_rd       = issue_s;
   assign mem_addr     = addr_r;
   assign char         = fifo_mem_r[rd_ptr_r];
   assign char_valid   = (count_r != {CNT_W{1'b0}});
   assign char_index   = idx_r;
   assign busy         = busy_r;
   assign has_finished = finished_r;

endmodule
